adc_spi_sampler: RTL

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clkdiv.sv | 38 +++
 rtl/adc_spi_sampler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the ADC SPI sampler.
//   spi_state_t  : frame sequencer states (IDLE, SETUP, HIGH, LOW, HOLD, GAP)
//   frame_cycles : number of clk cycles adc_ss is held low for one frame
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

  // One SETUP phase, NBITS high/low pairs, one HOLD phase, each CLKDIV long.
  function automatic int frame_cycles(input int clkdiv, input int nbits);
    return clkdiv * (2 * nbits + 2);
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Bit-timing divider for the SPI sequencer.
// Produces a one-cycle tick every CLKDIV clk cycles while run is high.
// The count is held at zero while run is low and is forced back to zero
// by restart, so the first tick after (re)start lands exactly CLKDIV
// cycles later.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   run     : count enable
//   restart : synchronously clears the count
//   tick    : high for the last cycle of each CLKDIV-cycle phase
module spi_clkdiv #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI master that reads one NBITS frame from an ADC every PERIOD
// clk cycles (mode 0, MSB first) and offers the result through a
// valid/ready style hold register with a sticky overrun flag.
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   enable       : allows the period counter to run and raise frame starts
//   cmd          : word shifted out on adc_mosi, latched at frame start
//   adc_ss       : slave select, active low
//   adc_sclk     : SPI clock, idle low
//   adc_mosi     : SPI data to ADC (0 while adc_ss is high)
//   adc_miso     : SPI data from ADC
//   sample       : last captured frame
//   sample_valid : sample holds unconsumed data
//   sample_ready : consumer accepts sample this cycle
//   overrun      : sticky, a sample was overwritten before being consumed
//   busy         : frame in progress (inverse of adc_ss)
module adc_spi_sampler
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int PERIOD = 1000,
  parameter int NBITS  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NBITS-1:0] cmd,
  output logic             adc_ss,
  output logic             adc_sclk,
  output logic             adc_mosi,
  input  logic             adc_miso,
  output logic [NBITS-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS);

  spi_state_t       state;
  logic [PW-1:0]    per_cnt;
  logic             wrap;
  logic             pending;
  logic             start_go;
  logic             div_run;
  logic             div_tick;
  logic [NBITS-1:0] tx_sh;
  logic [NBITS-1:0] rx_sh;
  logic [BW-1:0]    bit_cnt;

  // Period counter: a start request is the cycle it wraps back to zero.
  assign wrap = enable && (per_cnt == PER_LAST);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      per_cnt <= '0;
    end else if (wrap) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PW'(1);
    end
  end

  // A request seen while a frame is running is remembered and taken on the
  // first IDLE cycle; any number of such requests collapse into one.
  assign start_go = (state == IDLE) && (wrap || pending);
  assign div_run  = (state != IDLE);

  spi_clkdiv #(
    .CLKDIV (CLKDIV)
  ) u_clkdiv (
    .clk     (clk),
    .reset   (reset),
    .run     (div_run),
    .restart (start_go),
    .tick    (div_tick)
  );

  // The transmit shifter's MSB is the mosi pin itself; it shifts in zeros,
  // so it is already all-zero once the last bit has gone out and the pin
  // stays low between frames.
  assign adc_mosi = tx_sh[NBITS-1];
  assign busy     = ~adc_ss;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      adc_ss       <= 1'b1;
      adc_sclk     <= 1'b0;
      tx_sh        <= '0;
      bit_cnt      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (start_go) begin
        pending <= 1'b0;
      end else if (wrap) begin
        pending <= 1'b1;
      end

      // Consumer handshake; a load in HOLD below overrides this clear.
      if (sample_ready) begin
        sample_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_go) begin
            state   <= SETUP;
            adc_ss  <= 1'b0;
            tx_sh   <= cmd;
            bit_cnt <= '0;
          end
        end

        SETUP: begin
          if (div_tick) begin
            state    <= HIGH;
            adc_sclk <= 1'b1;
            rx_sh    <= {rx_sh[NBITS-2:0], adc_miso};
          end
        end

        HIGH: begin
          if (div_tick) begin
            state    <= LOW;
            adc_sclk <= 1'b0;
            tx_sh    <= {tx_sh[NBITS-2:0], 1'b0};
            bit_cnt  <= bit_cnt + BW'(1);
          end
        end

        LOW: begin
          if (div_tick) begin
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              state    <= HIGH;
              adc_sclk <= 1'b1;
              rx_sh    <= {rx_sh[NBITS-2:0], adc_miso};
            end
          end
        end

        HOLD: begin
          if (div_tick) begin
            state        <= GAP;
            adc_ss       <= 1'b1;
            tx_sh        <= '0;
            sample       <= rx_sh;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready) begin
              overrun <= 1'b1;
            end
          end
        end

        GAP: begin
          if (div_tick) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
